mem_stage_lsu: RTL and testbench

Parametrised successor of the fixed-latency memory stage. Sits between EX and WB and owns the EX->MEM pipeline register. Drives a request/response data bus with arbitrary wait states and stalls the pipeline while an access is outstanding. Adds XLEN=32/64 lane extraction, store strobes, misalignment exceptions and a load-pending forwarding flag.

---
 rtl/mem_stage_lsu.sv | 187 ++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// MEM stage load/store unit: owns the EX->MEM pipeline register and drives a
// request/response data bus with wait states, lane steering and alignment checks.
module mem_stage_lsu #(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              ex_valid,
  input  logic [6:0]        ex_lsu_op,
  input  logic [XLEN-1:0]   ex_addr,
  input  logic [XLEN-1:0]   ex_wdata,
  input  logic [XLEN-1:0]   ex_result,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic              ex_rf_we,
  input  logic [4:0]        ex_rf_waddr,
  output logic              dreq_valid,
  input  logic              dreq_ready,
  output logic              dreq_we,
  output logic [XLEN-1:0]   dreq_addr,
  output logic [XLEN-1:0]   dreq_wdata,
  output logic [XLEN/8-1:0] dreq_strb,
  input  logic              drsp_valid,
  input  logic [XLEN-1:0]   drsp_rdata,
  output logic              stall_req,
  output logic              wb_valid,
  output logic              wb_rf_we,
  output logic [4:0]        wb_rf_waddr,
  output logic [XLEN-1:0]   wb_rf_wdata,
  output logic [XLEN-1:0]   wb_pc,
  output logic              fwd_rf_we,
  output logic [4:0]        fwd_rf_waddr,
  output logic [XLEN-1:0]   fwd_data,
  output logic              fwd_pending,
  output logic              exc_valid,
  output logic [XLEN-1:0]   exc_addr
);
  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned LB = $clog2(NB);

  // lsu_op layout: {en, we, d, w, h, b, unsigned}
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t state, state_nx;

  logic            valid_r, rf_we_r;
  logic [6:0]      op_r;
  logic [4:0]      rf_waddr_r;
  logic [XLEN-1:0] addr_r, wdata_r, result_r, pc_r, rdata_r;

  logic capture, bubble, ex_go;
  logic unused_stall_bits;

  function automatic logic bad_access(input logic [6:0] op, input logic [XLEN-1:0] a);
    logic mis, ill;
    mis = (op[2] & a[0]) | (op[3] & (a[1:0] != 2'b00)) | (op[4] & (a[2:0] != 3'b000));
    ill = op[4] & (XLEN == 32);
    return mis | ill;
  endfunction

  assign capture = ~stall[3];
  assign bubble  = stall[3] & ~stall[4];
  assign ex_go   = ex_valid & ex_lsu_op[6] & ~bad_access(ex_lsu_op, ex_addr);
  assign unused_stall_bits = ^{stall[5], stall[2:0]};

  // EX->MEM pipeline register
  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      valid_r    <= 1'b0;
      op_r       <= '0;
      addr_r     <= '0;
      wdata_r    <= '0;
      result_r   <= '0;
      pc_r       <= '0;
      rf_we_r    <= 1'b0;
      rf_waddr_r <= '0;
    end else if (capture) begin
      valid_r    <= ex_valid;
      op_r       <= ex_lsu_op;
      addr_r     <= ex_addr;
      wdata_r    <= ex_wdata;
      result_r   <= ex_result;
      pc_r       <= ex_pc;
      rf_we_r    <= ex_rf_we;
      rf_waddr_r <= ex_rf_waddr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      rdata_r <= '0;
    end else begin
      state <= state_nx;
      if (state == S_WAIT && state_nx == S_DONE) rdata_r <= drsp_rdata;
    end
  end

  // Next state; a capturing edge always restarts the sequence for the new slot
  always_comb begin
    state_nx   = state;
    dreq_valid = 1'b0;
    stall_req  = 1'b0;
    if (bubble) begin
      state_nx = S_IDLE;
    end else if (capture) begin
      state_nx = ex_go ? S_REQ : S_IDLE;
    end else begin
      case (state)
        S_REQ:   if (dreq_ready) state_nx = S_WAIT;
        S_WAIT:  if (drsp_valid) state_nx = S_DONE;
        default: state_nx = state;
      endcase
    end
    dreq_valid = (state == S_REQ);
    stall_req  = (state == S_REQ) || (state == S_WAIT);
  end

  logic            is_mem, is_exc, is_load, is_store;
  logic [LB-1:0]   lane;
  logic [NB-1:0]   mask, strb_sh;
  logic [XLEN-1:0] wdata_lane, shifted, keep, ld_data;
  logic            msb;

  assign is_mem   = valid_r & op_r[6];
  assign is_exc   = is_mem & bad_access(op_r, addr_r);
  assign is_load  = is_mem & ~op_r[5];
  assign is_store = is_mem & op_r[5];
  assign lane     = addr_r[LB-1:0];
  assign shifted  = rdata_r >> {lane, 3'b000};
  assign strb_sh  = mask << lane;

  // Store lane replication and byte mask
  always_comb begin
    wdata_lane = wdata_r;
    mask       = '0;
    if (op_r[1]) begin
      wdata_lane = {NB{wdata_r[7:0]}};
      mask       = NB'(1);
    end else if (op_r[2]) begin
      wdata_lane = {(NB/2){wdata_r[15:0]}};
      mask       = NB'(3);
    end else if (op_r[3]) begin
      wdata_lane = {(NB/4){wdata_r[31:0]}};
      mask       = NB'(15);
    end else if (op_r[4]) begin
      mask       = NB'(255);
    end
  end

  // Load extension: keep the access width, fill the rest with sign or zero
  always_comb begin
    keep = '1;
    msb  = 1'b0;
    if (op_r[1]) begin
      keep = XLEN'(8'hFF);
      msb  = shifted[7];
    end else if (op_r[2]) begin
      keep = XLEN'(16'hFFFF);
      msb  = shifted[15];
    end else if (op_r[3]) begin
      keep = XLEN'(32'hFFFF_FFFF);
      msb  = shifted[31];
    end
    ld_data = (shifted & keep) | ((msb & ~op_r[0]) ? ~keep : '0);
  end

  assign dreq_we      = dreq_valid & op_r[5];
  assign dreq_addr    = dreq_valid ? (addr_r & ~XLEN'(NB - 1)) : '0;
  assign dreq_wdata   = (dreq_valid & op_r[5]) ? wdata_lane : '0;
  assign dreq_strb    = (dreq_valid & op_r[5]) ? strb_sh : '0;

  assign wb_valid     = valid_r & (~is_mem | is_exc | (state == S_DONE));
  assign wb_rf_we     = wb_valid & rf_we_r & ~is_exc & ~is_store;
  assign wb_rf_waddr  = rf_waddr_r;
  assign wb_rf_wdata  = is_load ? ld_data : result_r;
  assign wb_pc        = pc_r;

  assign fwd_rf_we    = valid_r & rf_we_r & ~is_exc;
  assign fwd_rf_waddr = rf_waddr_r;
  assign fwd_data     = wb_rf_wdata;
  assign fwd_pending  = is_load & ~is_exc & (state != S_DONE);

  assign exc_valid    = is_exc;
  assign exc_addr     = is_exc ? addr_r : '0;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: one XLEN=32 and one XLEN=64 instance share
// stimulus; each instance's stall_req freezes its own MEM and WB stages.
module tb_mem_stage_lsu;
  localparam logic [6:0] OP_ALU = 7'b000_0000;
  localparam logic [6:0] OP_LB  = 7'b100_0010;
  localparam logic [6:0] OP_LBU = 7'b100_0011;
  localparam logic [6:0] OP_SH  = 7'b110_0100;
  localparam logic [6:0] OP_LW  = 7'b100_1000;
  localparam logic [6:0] OP_LD  = 7'b101_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall_ext, a_stall, b_stall;
  logic        ex_valid, ex_rf_we, dreq_ready, drsp_valid;
  logic [6:0]  ex_lsu_op;
  logic [4:0]  ex_rf_waddr;
  logic [63:0] ex_addr, ex_wdata, ex_result, ex_pc, drsp_rdata;

  logic        a_dreq_valid, a_dreq_we, a_stall_req, a_wb_valid, a_wb_rf_we;
  logic        a_fwd_rf_we, a_fwd_pending, a_exc_valid;
  logic [31:0] a_dreq_addr, a_dreq_wdata, a_wb_rf_wdata, a_wb_pc, a_fwd_data, a_exc_addr;
  logic [3:0]  a_dreq_strb;
  logic [4:0]  a_wb_rf_waddr, a_fwd_rf_waddr;

  logic        b_dreq_valid, b_dreq_we, b_stall_req, b_wb_valid, b_wb_rf_we;
  logic        b_fwd_rf_we, b_fwd_pending, b_exc_valid;
  logic [63:0] b_dreq_addr, b_dreq_wdata, b_wb_rf_wdata, b_wb_pc, b_fwd_data, b_exc_addr;
  logic [7:0]  b_dreq_strb;
  logic [4:0]  b_wb_rf_waddr, b_fwd_rf_waddr;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign a_stall = stall_ext | (a_stall_req ? 6'b011000 : 6'b000000);
  assign b_stall = stall_ext | (b_stall_req ? 6'b011000 : 6'b000000);

  mem_stage_lsu #(.XLEN(32)) u32 (
    .clk(clk), .rst(rst), .stall(a_stall), .ex_valid(ex_valid), .ex_lsu_op(ex_lsu_op),
    .ex_addr(ex_addr[31:0]), .ex_wdata(ex_wdata[31:0]), .ex_result(ex_result[31:0]),
    .ex_pc(ex_pc[31:0]), .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr),
    .dreq_valid(a_dreq_valid), .dreq_ready(dreq_ready), .dreq_we(a_dreq_we),
    .dreq_addr(a_dreq_addr), .dreq_wdata(a_dreq_wdata), .dreq_strb(a_dreq_strb),
    .drsp_valid(drsp_valid), .drsp_rdata(drsp_rdata[31:0]), .stall_req(a_stall_req),
    .wb_valid(a_wb_valid), .wb_rf_we(a_wb_rf_we), .wb_rf_waddr(a_wb_rf_waddr),
    .wb_rf_wdata(a_wb_rf_wdata), .wb_pc(a_wb_pc), .fwd_rf_we(a_fwd_rf_we),
    .fwd_rf_waddr(a_fwd_rf_waddr), .fwd_data(a_fwd_data), .fwd_pending(a_fwd_pending),
    .exc_valid(a_exc_valid), .exc_addr(a_exc_addr)
  );

  mem_stage_lsu #(.XLEN(64)) u64 (
    .clk(clk), .rst(rst), .stall(b_stall), .ex_valid(ex_valid), .ex_lsu_op(ex_lsu_op),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_result(ex_result),
    .ex_pc(ex_pc), .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr),
    .dreq_valid(b_dreq_valid), .dreq_ready(dreq_ready), .dreq_we(b_dreq_we),
    .dreq_addr(b_dreq_addr), .dreq_wdata(b_dreq_wdata), .dreq_strb(b_dreq_strb),
    .drsp_valid(drsp_valid), .drsp_rdata(drsp_rdata), .stall_req(b_stall_req),
    .wb_valid(b_wb_valid), .wb_rf_we(b_wb_rf_we), .wb_rf_waddr(b_wb_rf_waddr),
    .wb_rf_wdata(b_wb_rf_wdata), .wb_pc(b_wb_pc), .fwd_rf_we(b_fwd_rf_we),
    .fwd_rf_waddr(b_fwd_rf_waddr), .fwd_data(b_fwd_data), .fwd_pending(b_fwd_pending),
    .exc_valid(b_exc_valid), .exc_addr(b_exc_addr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sreq(input bit w64);
    return w64 ? int'(b_stall_req) : int'(a_stall_req);
  endfunction

  // Present one instruction in EX for exactly one capturing edge
  task automatic issue(input logic [6:0] op, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [63:0] result, input logic we, input logic [4:0] wa);
    ex_valid = 1'b1; ex_lsu_op = op; ex_addr = addr; ex_wdata = wdata;
    ex_result = result; ex_pc = 64'h1000 + addr; ex_rf_we = we; ex_rf_waddr = wa;
    tick();
    ex_valid = 1'b0; ex_lsu_op = '0; ex_rf_we = 1'b0; ex_addr = '0;
  endtask

  // Bus slave: hold dreq_ready low for 'hold' cycles, accept, respond next cycle
  task automatic serve(input bit w64, input int hold, input logic [63:0] rdata, output int cycles);
    cycles = 0;
    dreq_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      cycles += sreq(w64);
      tick();
    end
    dreq_ready = 1'b1;
    cycles += sreq(w64);
    tick();
    dreq_ready = 1'b0; drsp_valid = 1'b1; drsp_rdata = rdata;
    cycles += sreq(w64);
    tick();
    drsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall_ext = '0; ex_valid = 1'b0; ex_lsu_op = '0; ex_addr = '0; ex_wdata = '0;
    ex_result = '0; ex_pc = '0; ex_rf_we = 1'b0; ex_rf_waddr = '0;
    dreq_ready = 1'b0; drsp_valid = 1'b1; drsp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick(); tick();
    drsp_valid = 1'b0;
    n_chk++; if ({a_dreq_valid, a_stall_req, a_wb_valid, a_fwd_pending, a_exc_valid} !== 5'b0) begin n_fail++; $display("FAIL reset_ctrl32: got %b expected 00000", {a_dreq_valid, a_stall_req, a_wb_valid, a_fwd_pending, a_exc_valid}); end
    n_chk++; if ({b_dreq_valid, b_stall_req, b_wb_valid, b_fwd_pending, b_exc_valid} !== 5'b0) begin n_fail++; $display("FAIL reset_ctrl64: got %b expected 00000", {b_dreq_valid, b_stall_req, b_wb_valid, b_fwd_pending, b_exc_valid}); end
    rst = 1'b0;
    tick();
    n_chk++; if (a_wb_rf_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata32: got %h expected 00000000", a_wb_rf_wdata); end
  endtask

  task automatic test_load_word();
    int cyc;
    issue(OP_LW, 64'h104, 64'h0, 64'h0, 1'b1, 5'd5);
    n_chk++; if ({a_dreq_valid, a_dreq_we, a_dreq_addr} !== {1'b1, 1'b0, 32'h104}) begin n_fail++; $display("FAIL lw_req: got v=%b we=%b addr=%h expected v=1 we=0 addr=00000104", a_dreq_valid, a_dreq_we, a_dreq_addr); end
    n_chk++; if ({a_stall_req, a_fwd_pending, a_fwd_rf_we, a_wb_valid} !== 4'b1110) begin n_fail++; $display("FAIL lw_req_flags: got %b expected 1110", {a_stall_req, a_fwd_pending, a_fwd_rf_we, a_wb_valid}); end
    serve(1'b0, 0, 64'h0000_0000_8000_00F0, cyc);
    n_chk++; if (cyc !== 2) begin n_fail++; $display("FAIL lw_stall_cycles: got %0d expected 2", cyc); end
    n_chk++; if ({a_wb_valid, a_wb_rf_we, a_wb_rf_waddr} !== {1'b1, 1'b1, 5'd5}) begin n_fail++; $display("FAIL lw_done_ctrl: got v=%b we=%b wa=%0d expected v=1 we=1 wa=5", a_wb_valid, a_wb_rf_we, a_wb_rf_waddr); end
    n_chk++; if (a_wb_rf_wdata !== 32'h8000_00F0) begin n_fail++; $display("FAIL lw_data: got %h expected 800000f0", a_wb_rf_wdata); end
    n_chk++; if ({a_stall_req, a_fwd_pending, a_dreq_valid} !== 3'b000) begin n_fail++; $display("FAIL lw_done_flags: got %b expected 000", {a_stall_req, a_fwd_pending, a_dreq_valid}); end
    n_chk++; if (a_wb_pc !== 32'h1104) begin n_fail++; $display("FAIL lw_pc: got %h expected 00001104", a_wb_pc); end
    stall_ext = 6'b011000;
    tick();
    n_chk++; if ({a_wb_valid, a_dreq_valid, a_wb_rf_wdata} !== {1'b1, 1'b0, 32'h8000_00F0}) begin n_fail++; $display("FAIL done_hold: got v=%b req=%b d=%h expected v=1 req=0 d=800000f0", a_wb_valid, a_dreq_valid, a_wb_rf_wdata); end
    stall_ext = '0;
    tick();
    n_chk++; if (a_wb_valid !== 1'b0) begin n_fail++; $display("FAIL done_release: got %b expected 0", a_wb_valid); end
  endtask

  task automatic test_load_byte();
    int cyc;
    issue(OP_LB, 64'h103, 64'h0, 64'h0, 1'b1, 5'd6);
    serve(1'b0, 0, 64'h0000_0000_8012_3456, cyc);
    n_chk++; if (a_wb_rf_wdata !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_sext: got %h expected ffffff80", a_wb_rf_wdata); end
    n_chk++; if (a_fwd_data !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_fwd: got %h expected ffffff80", a_fwd_data); end
    tick();
    issue(OP_LBU, 64'h103, 64'h0, 64'h0, 1'b1, 5'd6);
    serve(1'b0, 0, 64'h0000_0000_8012_3456, cyc);
    n_chk++; if (a_wb_rf_wdata !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_zext: got %h expected 00000080", a_wb_rf_wdata); end
    tick();
  endtask

  task automatic test_store_half();
    int cyc = 0;
    issue(OP_SH, 64'h102, 64'h1234_ABCD, 64'h0, 1'b0, 5'd0);
    dreq_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) dreq_ready = 1'b1;
      n_chk++; if ({a_dreq_valid, a_dreq_we, a_dreq_addr, a_dreq_wdata, a_dreq_strb} !== {1'b1, 1'b1, 32'h100, 32'hABCD_ABCD, 4'b1100}) begin n_fail++; $display("FAIL sh_req_stable[%0d]: got v=%b we=%b a=%h d=%h s=%b expected v=1 we=1 a=00000100 d=abcdabcd s=1100", i, a_dreq_valid, a_dreq_we, a_dreq_addr, a_dreq_wdata, a_dreq_strb); end
      cyc += sreq(1'b0);
      tick();
    end
    dreq_ready = 1'b0; drsp_valid = 1'b1; drsp_rdata = '0;
    cyc += sreq(1'b0);
    tick();
    drsp_valid = 1'b0;
    n_chk++; if (cyc !== 5) begin n_fail++; $display("FAIL sh_stall_cycles: got %0d expected 5", cyc); end
    n_chk++; if ({a_wb_valid, a_wb_rf_we, a_dreq_valid, a_stall_req} !== 4'b1000) begin n_fail++; $display("FAIL sh_done: got %b expected 1000", {a_wb_valid, a_wb_rf_we, a_dreq_valid, a_stall_req}); end
    tick();
  endtask

  task automatic test_misaligned();
    issue(OP_LW, 64'h101, 64'h0, 64'h55, 1'b1, 5'd3);
    n_chk++; if ({a_exc_valid, a_exc_addr} !== {1'b1, 32'h101}) begin n_fail++; $display("FAIL mis_exc: got v=%b a=%h expected v=1 a=00000101", a_exc_valid, a_exc_addr); end
    n_chk++; if ({a_dreq_valid, a_stall_req, a_fwd_rf_we, a_wb_rf_we, a_fwd_pending} !== 5'b0) begin n_fail++; $display("FAIL mis_quiet: got %b expected 00000", {a_dreq_valid, a_stall_req, a_fwd_rf_we, a_wb_rf_we, a_fwd_pending}); end
    n_chk++; if (a_wb_valid !== 1'b1) begin n_fail++; $display("FAIL mis_wb_valid: got %b expected 1", a_wb_valid); end
    tick();
    n_chk++; if ({a_exc_valid, a_dreq_valid, a_wb_valid} !== 3'b000) begin n_fail++; $display("FAIL mis_after: got %b expected 000", {a_exc_valid, a_dreq_valid, a_wb_valid}); end
  endtask

  task automatic test_xlen64();
    int cyc;
    issue(OP_LD, 64'h10, 64'h0, 64'h0, 1'b1, 5'd9);
    n_chk++; if ({a_exc_valid, a_exc_addr, a_dreq_valid} !== {1'b1, 32'h10, 1'b0}) begin n_fail++; $display("FAIL ld_illegal32: got v=%b a=%h req=%b expected v=1 a=00000010 req=0", a_exc_valid, a_exc_addr, a_dreq_valid); end
    n_chk++; if ({b_dreq_valid, b_dreq_addr, b_exc_valid} !== {1'b1, 64'h10, 1'b0}) begin n_fail++; $display("FAIL ld_req64: got v=%b a=%h exc=%b expected v=1 a=10 exc=0", b_dreq_valid, b_dreq_addr, b_exc_valid); end
    serve(1'b1, 0, 64'h0123_4567_89AB_CDEF, cyc);
    n_chk++; if (b_wb_rf_wdata !== 64'h0123_4567_89AB_CDEF) begin n_fail++; $display("FAIL ld_data64: got %h expected 0123456789abcdef", b_wb_rf_wdata); end
    n_chk++; if ({b_wb_valid, b_wb_rf_we, b_wb_rf_waddr} !== {1'b1, 1'b1, 5'd9}) begin n_fail++; $display("FAIL ld_ctrl64: got v=%b we=%b wa=%0d expected v=1 we=1 wa=9", b_wb_valid, b_wb_rf_we, b_wb_rf_waddr); end
    tick();
    issue(OP_LW, 64'h14, 64'h0, 64'h0, 1'b1, 5'd10);
    serve(1'b1, 1, 64'h0123_4567_89AB_CDEF, cyc);
    n_chk++; if (b_wb_rf_wdata !== 64'h0000_0000_0123_4567) begin n_fail++; $display("FAIL lw_hi64: got %h expected 0000000001234567", b_wb_rf_wdata); end
    n_chk++; if (cyc !== 3) begin n_fail++; $display("FAIL lw_hi64_cycles: got %0d expected 3", cyc); end
    tick();
    issue(OP_LW, 64'h10, 64'h0, 64'h0, 1'b1, 5'd11);
    serve(1'b1, 0, 64'h0123_4567_89AB_CDEF, cyc);
    n_chk++; if (b_wb_rf_wdata !== 64'hFFFF_FFFF_89AB_CDEF) begin n_fail++; $display("FAIL lw_lo64_sext: got %h expected ffffffff89abcdef", b_wb_rf_wdata); end
    tick();
  endtask

  task automatic test_reset_mid_access();
    issue(OP_LW, 64'h104, 64'h0, 64'h0, 1'b1, 5'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++; if ({a_dreq_valid, a_stall_req} !== 2'b00) begin n_fail++; $display("FAIL rst_in_req: got %b expected 00", {a_dreq_valid, a_stall_req}); end
    issue(OP_LW, 64'h104, 64'h0, 64'h0, 1'b1, 5'd4);
    dreq_ready = 1'b1;
    tick();
    dreq_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++; if ({a_dreq_valid, a_stall_req, a_wb_valid, a_wb_rf_we, a_fwd_rf_we, a_fwd_pending, a_exc_valid} !== 7'b0) begin n_fail++; $display("FAIL rst_in_wait_ctrl: got %b expected 0000000", {a_dreq_valid, a_stall_req, a_wb_valid, a_wb_rf_we, a_fwd_rf_we, a_fwd_pending, a_exc_valid}); end
    n_chk++; if ({a_wb_rf_wdata, a_wb_pc, a_wb_rf_waddr} !== 69'b0) begin n_fail++; $display("FAIL rst_in_wait_data: got d=%h pc=%h wa=%0d expected all 0", a_wb_rf_wdata, a_wb_pc, a_wb_rf_waddr); end
    drsp_valid = 1'b1; drsp_rdata = 64'h0000_0000_DEAD_BEEF;
    tick();
    drsp_valid = 1'b0;
    n_chk++; if ({a_stall_req, a_wb_valid, a_fwd_pending} !== 3'b000) begin n_fail++; $display("FAIL stale_rsp: got %b expected 000", {a_stall_req, a_wb_valid, a_fwd_pending}); end
    issue(OP_ALU, 64'h20, 64'h0, 64'hCAFE, 1'b1, 5'd7);
    n_chk++; if ({a_wb_valid, a_wb_rf_we, a_fwd_rf_we, a_stall_req} !== 4'b1110) begin n_fail++; $display("FAIL alu_after_rst: got %b expected 1110", {a_wb_valid, a_wb_rf_we, a_fwd_rf_we, a_stall_req}); end
    n_chk++; if (a_wb_rf_wdata !== 32'h0000_CAFE) begin n_fail++; $display("FAIL alu_after_rst_data: got %h expected 0000cafe", a_wb_rf_wdata); end
  endtask

  task automatic test_back_to_back();
    issue(OP_ALU, 64'h0, 64'h0, 64'h11, 1'b1, 5'd1);
    n_chk++; if ({a_wb_valid, a_wb_rf_wdata, a_wb_pc} !== {1'b1, 32'h11, 32'h1000}) begin n_fail++; $display("FAIL b2b_first: got v=%b d=%h pc=%h expected v=1 d=00000011 pc=00001000", a_wb_valid, a_wb_rf_wdata, a_wb_pc); end
    issue(OP_ALU, 64'h4, 64'h0, 64'h22, 1'b1, 5'd2);
    n_chk++; if ({a_wb_valid, a_wb_rf_wdata, a_fwd_rf_waddr} !== {1'b1, 32'h22, 5'd2}) begin n_fail++; $display("FAIL b2b_second: got v=%b d=%h wa=%0d expected v=1 d=00000022 wa=2", a_wb_valid, a_wb_rf_wdata, a_fwd_rf_waddr); end
    stall_ext = 6'b001000;
    tick();
    stall_ext = '0;
    n_chk++; if ({a_wb_valid, a_fwd_rf_we} !== 2'b00) begin n_fail++; $display("FAIL mem_bubble: got %b expected 00", {a_wb_valid, a_fwd_rf_we}); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load_word();
    test_load_byte();
    test_store_half();
    test_misaligned();
    test_xlen64();
    test_reset_mid_access();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
